// File: rtl/par_word_source_pkg.sv
// par_word_source_pkg: shared definitions for the parallel word source and the
// receive-side checker that reuses its word pattern.
// Holds the FSM state encoding, default widths and the LFSR tap constant used
// when PAR_WORD_SOURCE_LFSR_EN is defined.
package par_word_source_pkg;

    localparam int DWID_DEF   = 32;
    localparam int CNTWID_DEF = 16;
    localparam int GAPWID_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
    // (bit k-1 set for each x^k term).
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/par_word_source_if.sv
// par_word_source_if: control inputs and serdes-facing outputs of the word source.
// Handshake: par_valid is a one-cycle strobe per word with no ready/back-pressure;
// the consumer must take par_data on every cycle par_valid is high, and par_data
// only carries meaning on those cycles.
interface par_word_source_if
    import par_word_source_pkg::*;
#(
    parameter int DWid   = DWID_DEF,
    parameter int CntWid = CNTWID_DEF,
    parameter int GapWid = GAPWID_DEF
) ();

    logic              start;
    logic              abort;
    logic              hold;
    logic [DWid-1:0]   seed;
    logic [CntWid-1:0] burst_len;
    logic [GapWid-1:0] gap_len;

    logic [DWid-1:0]   par_data;
    logic              par_valid;
    logic              busy;
    logic              done;
    logic [CntWid-1:0] word_count;

    // The word source itself.
    modport master (
        input  start, abort, hold, seed, burst_len, gap_len,
        output par_data, par_valid, busy, done, word_count
    );

    // Whoever controls the source and consumes its words.
    modport slave (
        output start, abort, hold, seed, burst_len, gap_len,
        input  par_data, par_valid, busy, done, word_count
    );

endinterface

// File: rtl/par_word_source_next.sv
// par_word_next: combinational successor of a generated word.
// Default build increments modulo 2^DWid; with PAR_WORD_SOURCE_LFSR_EN defined
// it steps a right-shifting Galois LFSR instead. Kept separate so the receive
// side can regenerate the same sequence.
module par_word_next
    import par_word_source_pkg::*;
#(
    parameter int DWid = DWID_DEF
) (
    input  logic [DWid-1:0] cur_i,
    output logic [DWid-1:0] nxt_o
);

`ifdef PAR_WORD_SOURCE_LFSR_EN
    // Only the 32-bit mask is maximal length; other widths fall back to a
    // simple end-tap mask that still avoids an all-zero successor.
    localparam logic [DWid-1:0] TAPS = (DWid == 32) ? DWid'(LFSR_TAPS_32)
                                     : (DWid'(1) | (DWid'(1) << (DWid - 1)));

    // One Galois step: shift right, fold the taps in when a one falls out.
    always_comb begin
        nxt_o = cur_i[0] ? ((cur_i >> 1) ^ TAPS) : (cur_i >> 1);
    end
`else
    // Incrementing pattern, wraps from all-ones to zero.
    always_comb begin
        nxt_o = cur_i + DWid'(1);
    end
`endif

endmodule

// File: rtl/par_word_source.sv
// par_word_source: generates bursts of parallel words for the serdes transmit side.
// Burst length, inter-word gap and start word are captured on Start; Hold freezes
// progress, Abort returns to IDLE without a Done pulse. All outputs are registered.
// Build macro PAR_WORD_SOURCE_LFSR_EN selects the LFSR word pattern (a zero Seed
// then starts from all-ones); otherwise words increment.
module par_word_source
    import par_word_source_pkg::*;
#(
    parameter int DWid   = DWID_DEF,
    parameter int CntWid = CNTWID_DEF,
    parameter int GapWid = GAPWID_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    par_word_source_if.master bus,
    output state_e            state_o
);

    state_e            state_q;
    logic [DWid-1:0]   word_q;
    logic [DWid-1:0]   word_d;
    logic [DWid-1:0]   seed_d;
    logic [CntWid-1:0] burst_len_q;
    logic [GapWid-1:0] gap_len_q;
    logic [GapWid-1:0] gap_cnt_q;
    logic [CntWid-1:0] word_count_q;
    logic [CntWid-1:0] count_inc_d;
    logic [DWid-1:0]   par_data_q;
    logic              par_valid_q;
    logic              busy_q;
    logic              done_q;

    par_word_next #(.DWid(DWid)) u_next (
        .cur_i (word_q),
        .nxt_o (word_d)
    );

`ifdef PAR_WORD_SOURCE_LFSR_EN
    // An all-zero LFSR state never leaves zero, so start from all-ones instead.
    assign seed_d = (bus.seed == '0) ? '1 : bus.seed;
`else
    assign seed_d = bus.seed;
`endif

    // Count never reaches all-ones before the last word, so this cannot wrap
    // while it is used.
    assign count_inc_d = word_count_q + CntWid'(1);

    // Burst FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            burst_len_q  <= '0;
            gap_len_q    <= '0;
            gap_cnt_q    <= '0;
            word_count_q <= '0;
            par_data_q   <= '0;
            par_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            par_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (bus.abort) begin
                // Abort beats Hold and Start; the word count is kept for inspection.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            word_q       <= seed_d;
                            burst_len_q  <= bus.burst_len;
                            gap_len_q    <= bus.gap_len;
                            word_count_q <= '0;
                            if (bus.burst_len != '0) begin
                                state_q <= ST_SEND;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_SEND: begin
                        if (!bus.hold) begin
                            par_valid_q  <= 1'b1;
                            par_data_q   <= word_q;
                            word_q       <= word_d;
                            word_count_q <= count_inc_d;
                            if (count_inc_d == burst_len_q) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                            end else if (gap_len_q != '0) begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= gap_len_q;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (!bus.hold) begin
                            if (gap_cnt_q == GapWid'(1)) begin
                                state_q <= ST_SEND;
                            end else begin
                                gap_cnt_q <= gap_cnt_q - GapWid'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.par_data   = par_data_q;
    assign bus.par_valid  = par_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.word_count = word_count_q;
    assign state_o        = state_q;

endmodule

// File: doc/par_word_source.md
Name: par_word_source

Overview:
- Upstream stimulus stage for the full-duplex serdes pair.
- Generates bursts of DWid-bit parallel words, each qualified by a one-cycle valid strobe, in the transmitting side's parallel clock domain.
- Outputs drive a serdes parallel data input, its parallel-valid input and its transmit request directly.
- Burst length, inter-word gap and start word are run-time inputs. A done strobe and word counter support self-checking benches.

Parameters:
- DWid, 32, width of the generated parallel data word.
- CntWid, 16, width of burst length and word counter.
- GapWid, 8, width of the inter-word gap length.

Ports:
- Clock  input  1  parallel-side clock; all state advances on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  starts a burst; sampled only in IDLE.
- Abort  input  1  synchronous abort; returns to IDLE from any state.
- Hold  input  1  freezes SEND/GAP progress while high.
- Seed  input  DWid  first word of the burst; captured on the Start cycle.
- BurstLen  input  CntWid  words per burst; captured on Start.
- GapLen  input  GapWid  idle cycles between words; captured on Start.
- ParDataOut  output  DWid  generated word; drives the serdes parallel data input.
- ParValid  output  1  one-cycle strobe per word; drives the serdes parallel-valid and transmit request inputs.
- Busy  output  1  high in SEND and GAP.
- Done  output  1  one-cycle pulse at normal burst completion.
- WordCount  output  CntWid  words emitted in the current or last burst.

Behaviour:
- Reset (asynchronous, high): state = IDLE; ParDataOut = 0, ParValid = 0, Busy = 0, Done = 0, WordCount = 0.
- All outputs are registered.
- States: IDLE, SEND, GAP, DONE.
- IDLE, Start = 1 and BurstLen != 0:
  - Capture Seed, BurstLen and GapLen; clear WordCount; go to SEND.
  - First ParValid appears on the cycle after the Start edge (latency 1).
- IDLE, Start = 1 and BurstLen == 0: no words; go to DONE, so Done pulses 1 cycle later.
- SEND (Hold = 0):
  - ParValid = 1 with ParDataOut = current word; WordCount += 1; next word = current + 1, mod 2^DWid (wraps from all-ones to 0).
  - If WordCount + 1 == captured BurstLen, go to DONE.
  - Else if GapLen == 0, stay in SEND (back-to-back words).
  - Else go to GAP with the gap counter loaded to GapLen.
- GAP (Hold = 0): ParValid = 0; gap counter decrements each cycle; at 1, go to SEND. Exactly GapLen invalid cycles separate consecutive valid words.
- Hold = 1 in SEND or GAP:
  - State, counters and next word are frozen; ParValid = 0.
  - On release, the interrupted word is emitted; no word is lost or duplicated.
- DONE: Done = 1 for one cycle; Busy = 0; then IDLE. ParDataOut holds the last word.
- Start outside IDLE is ignored. The captured BurstLen, GapLen and Seed are immune to input changes mid-burst.
- Abort:
  - Overrides Hold and Start. Next state is IDLE; ParValid = 0; Done is not asserted; WordCount keeps the count so far.
  - Abort and Start in the same IDLE cycle: stay in IDLE.
- Max burst: BurstLen = 2^CntWid - 1. WordCount never wraps within a burst.

Optional Feature:
- Macro PAR_WORD_SOURCE_LFSR_EN.
- Defined:
  - The next word comes from a DWid-bit Galois LFSR instead of an increment. Seed is the LFSR start state.
  - A Seed of 0 is replaced by all-ones, avoiding the lock-up state.
  - Sequence for DWid = 32 uses polynomial x^32+x^22+x^2+x+1.
- Undefined: incrementing pattern as above. Ports and timing are identical in both builds.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3);
  - LFSR tap constant for DWid = 32;
  - default widths.
- One sub-module, par_word_next: combinational next-word function (increment or LFSR, selected by the macro). This makes the pattern reusable by the receive-side checker.

Test Plan:
- Reset mid-burst (after 3 of 8 words) -> all outputs 0 immediately, state IDLE; a subsequent Start runs a full burst.
- Seed = 32'h10, BurstLen = 4, GapLen = 0, Start pulse -> ParValid high 4 consecutive cycles starting 1 cycle after Start, with data 10, 11, 12, 13; Done 1 cycle after the last word; WordCount = 4.
- Seed = 32'hFFFF_FFFE, BurstLen = 3, GapLen = 2 -> data FFFF_FFFE, FFFF_FFFF, 0000_0000, each separated by exactly 2 invalid cycles.
- BurstLen = 0, Start -> no ParValid; Done pulses once; WordCount = 0.
- BurstLen = 6, Hold high for 5 cycles after the 2nd word, Abort asserted after the 4th word -> no words during Hold, data contiguous across Hold, no Done, WordCount = 4.
- PAR_WORD_SOURCE_LFSR_EN defined, Seed = 0, BurstLen = 3 -> first word 32'hFFFF_FFFF, then two LFSR successors matching the reference model.
